// File: rtl/rally_referee.sv
// rally_referee: consumes ball block events, keeps rally count and scores,
// declares the game winner and drives the hold/restart control back to the
// ball block.
//
// state | meaning
// IDLE  | ball held, waiting for a serve
// RALLY | ball in play, counting returns and watching for points
// POINT | ball held for HOLD_CYCLES after a point or let
// OVER  | game decided, scores frozen until the next serve
module rally_referee #(
  parameter int POS_W       = 16,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] ball_pos,
  input  logic             ball_return,
  input  logic             point_one,
  input  logic             point_two,
  input  logic             serve_btn,
  output logic             ball_hold,
  output logic             serve_side,
  output logic [3:0]       score_one,
  output logic [3:0]       score_two,
  output logic [7:0]       rally_cnt,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             pos_err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    WIN4      = 4'(WIN_SCORE);

  typedef enum logic [1:0] {S_IDLE, S_RALLY, S_POINT, S_OVER} state_t;

  state_t state, state_nxt;

  logic [HW-1:0] hold_cnt;
  logic          ret_q, p1_q, p2_q, srv_q;
  logic          ret_ev, p1_ev, p2_ev, srv_ev;
  logic          pos_onehot;
  logic          win_hit;

  assign ret_ev = ball_return & ~ret_q;
  assign p1_ev  = point_one & ~p1_q;
  assign p2_ev  = point_two & ~p2_q;
  assign srv_ev = serve_btn & ~srv_q;

  // exactly one bit set: nonzero and clearing the lowest set bit leaves zero
  assign pos_onehot = (ball_pos != '0) && ((ball_pos & (ball_pos - 1'b1)) == '0);

  assign win_hit = (score_one == WIN4) || (score_two == WIN4);

  // outputs decoded from the registered state only
  assign ball_hold = (state != S_RALLY);
  assign game_over = (state == S_OVER);

  // input history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= 1'b0;
      p1_q  <= 1'b0;
      p2_q  <= 1'b0;
      srv_q <= 1'b0;
    end else begin
      ret_q <= ball_return;
      p1_q  <= point_one;
      p2_q  <= point_two;
      srv_q <= serve_btn;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (srv_ev) state_nxt = S_RALLY;
      S_RALLY: if (p1_ev || p2_ev) state_nxt = S_POINT;
      S_POINT: if (hold_cnt == '0) state_nxt = win_hit ? S_OVER : S_IDLE;
      S_OVER:  if (srv_ev) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // scores, rally count, hold timer, serve side, winner and position fault
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      score_one  <= 4'd0;
      score_two  <= 4'd0;
      rally_cnt  <= 8'd0;
      serve_side <= 1'b0;
      winner     <= 2'b00;
      pos_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (srv_ev) rally_cnt <= 8'd0;
        end
        S_RALLY: begin
          if (!pos_onehot) pos_err <= 1'b1;
          if (ret_ev && rally_cnt != 8'hFF) rally_cnt <= rally_cnt + 8'd1;
          if (p1_ev || p2_ev) hold_cnt <= HOLD_LOAD;
          // simultaneous point edges are a let: no score change
          if (p1_ev && !p2_ev) score_one <= score_one + 4'd1;
          if (p2_ev && !p1_ev) score_two <= score_two + 4'd1;
        end
        S_POINT: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (win_hit) begin
            winner <= (score_one == WIN4) ? 2'b01 : 2'b10;
          end else begin
            serve_side <= ~serve_side;
          end
        end
        S_OVER: begin
          if (srv_ev) begin
            score_one  <= 4'd0;
            score_two  <= 4'd0;
            rally_cnt  <= 8'd0;
            winner     <= 2'b00;
            serve_side <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rally_referee.sv
// Directed bench for rally_referee with WIN_SCORE = 3 and HOLD_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each tick() is one clock of latency.
module tb_rally_referee;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ball_pos;
  logic        ball_return, point_one, point_two, serve_btn;
  logic        ball_hold, serve_side, game_over, pos_err;
  logic [3:0]  score_one, score_two;
  logic [7:0]  rally_cnt;
  logic [1:0]  winner;

  int checks = 0;
  int errors = 0;

  rally_referee #(.POS_W(16), .WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ball_pos(ball_pos), .ball_return(ball_return),
    .point_one(point_one), .point_two(point_two), .serve_btn(serve_btn),
    .ball_hold(ball_hold), .serve_side(serve_side), .score_one(score_one),
    .score_two(score_two), .rally_cnt(rally_cnt), .game_over(game_over),
    .winner(winner), .pos_err(pos_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve();
    serve_btn = 1'b1; tick();
    serve_btn = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ball_pos = 16'h0001; ball_return = 0; point_one = 0; point_two = 0; serve_btn = 0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({ball_hold, serve_side, score_one, score_two, rally_cnt, game_over, winner, pos_err} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: hold=%b side=%b s1=%0d s2=%0d rally=%0d over=%b win=%b perr=%b, required 1 0 0 0 0 0 00 0",
               ball_hold, serve_side, score_one, score_two, rally_cnt, game_over, winner, pos_err);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({ball_hold, score_one, score_two, rally_cnt, game_over, winner} !==
          {1'b1, 4'd0, 4'd0, 8'd0, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: hold=%b s1=%0d s2=%0d rally=%0d over=%b win=%b", i,
                 ball_hold, score_one, score_two, rally_cnt, game_over, winner);
      end
    end
  endtask

  task automatic test_serve_rally();
    serve_btn = 1'b1; tick();
    checks++;
    if (ball_hold !== 1'b0) begin
      errors++; $display("FAIL serve_release: ball_hold=%b, required 0", ball_hold);
    end
    serve_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ball_pos = 16'h0001 << (i + 1);
      ball_return = 1'b1; tick();
      checks++;
      if (rally_cnt !== 8'(i + 1)) begin
        errors++; $display("FAIL rally_step %0d: rally_cnt=%0d, required %0d", i, rally_cnt, i + 1);
      end
      tick();
      ball_return = 1'b0; tick();
    end
    checks++;
    if (rally_cnt !== 8'd3 || pos_err !== 1'b0) begin
      errors++; $display("FAIL rally_total: rally_cnt=%0d pos_err=%b, required 3 0", rally_cnt, pos_err);
    end
  endtask

  task automatic test_point_hold();
    point_two = 1'b1; tick();
    checks++;
    if (score_two !== 4'd1 || ball_hold !== 1'b1 || serve_side !== 1'b0) begin
      errors++; $display("FAIL point_two_score: s2=%0d hold=%b side=%b, required 1 1 0", score_two, ball_hold, serve_side);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (serve_side !== 1'b0 || ball_hold !== 1'b1) begin
        errors++; $display("FAIL hold_window %0d: side=%b hold=%b, required 0 1", i, serve_side, ball_hold);
      end
    end
    tick();
    checks++;
    if (serve_side !== 1'b1) begin
      errors++; $display("FAIL hold_end_side: serve_side=%b, required 1", serve_side);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (score_two !== 4'd1 || score_one !== 4'd0 || ball_hold !== 1'b1) begin
      errors++; $display("FAIL no_double_count: s1=%0d s2=%0d hold=%b, required 0 1 1", score_one, score_two, ball_hold);
    end
    point_two = 1'b0; tick();
  endtask

  task automatic test_let();
    serve();
    point_one = 1'b1; point_two = 1'b1; tick();
    checks++;
    if (score_one !== 4'd0 || score_two !== 4'd1 || ball_hold !== 1'b1) begin
      errors++; $display("FAIL let_scores: s1=%0d s2=%0d hold=%b, required 0 1 1", score_one, score_two, ball_hold);
    end
    point_one = 1'b0; point_two = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (serve_side !== 1'b0) begin
      errors++; $display("FAIL let_side: serve_side=%b, required 0", serve_side);
    end
  endtask

  task automatic test_win();
    for (int r = 0; r < 3; r++) begin
      serve();
      point_one = 1'b1; tick();
      point_one = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (score_one !== 4'(r + 1)) begin
        errors++; $display("FAIL win_rally %0d: s1=%0d, required %0d", r, score_one, r + 1);
      end
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b01 || score_two !== 4'd1 || serve_side !== 1'b0) begin
      errors++; $display("FAIL game_won: over=%b win=%b s2=%0d side=%b, required 1 01 1 0", game_over, winner, score_two, serve_side);
    end
    point_two = 1'b1; tick(); point_two = 1'b0; tick();
    checks++;
    if (score_two !== 4'd1 || winner !== 2'b01 || game_over !== 1'b1) begin
      errors++; $display("FAIL over_frozen: s2=%0d win=%b over=%b, required 1 01 1", score_two, winner, game_over);
    end
    serve_btn = 1'b1; tick();
    checks++;
    if ({score_one, score_two, winner, game_over, rally_cnt, serve_side, ball_hold} !==
        {4'd0, 4'd0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL new_game: s1=%0d s2=%0d win=%b over=%b rally=%0d side=%b hold=%b, required 0 0 00 0 0 0 1",
                         score_one, score_two, winner, game_over, rally_cnt, serve_side, ball_hold);
    end
    serve_btn = 1'b0; tick();
    checks++;
    if (ball_hold !== 1'b1) begin
      errors++; $display("FAIL idle_after_over: ball_hold=%b, required 1", ball_hold);
    end
  endtask

  task automatic test_faults();
    serve();
    ball_pos = 16'h0003; tick();
    ball_pos = 16'h0001;
    checks++;
    if (pos_err !== 1'b1) begin
      errors++; $display("FAIL pos_err_set: pos_err=%b, required 1", pos_err);
    end
    point_two = 1'b1; tick(); point_two = 1'b0; tick();
    checks++;
    if (pos_err !== 1'b1 || score_two !== 4'd1) begin
      errors++; $display("FAIL pos_err_sticky: pos_err=%b s2=%0d, required 1 1", pos_err, score_two);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({ball_hold, serve_side, score_one, score_two, rally_cnt, game_over, winner, pos_err} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL mid_point_reset: hold=%b side=%b s1=%0d s2=%0d rally=%0d over=%b win=%b perr=%b, required 1 0 0 0 0 0 00 0",
               ball_hold, serve_side, score_one, score_two, rally_cnt, game_over, winner, pos_err);
    end
  endtask

  task automatic test_back_to_back();
    serve();
    ball_return = 1'b1; point_one = 1'b1; tick();
    checks++;
    if (rally_cnt !== 8'd1 || score_one !== 4'd1 || ball_hold !== 1'b1) begin
      errors++; $display("FAIL return_with_point: rally=%0d s1=%0d hold=%b, required 1 1 1", rally_cnt, score_one, ball_hold);
    end
    ball_return = 1'b0; point_one = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_saturation();
    serve();
    checks++;
    if (rally_cnt !== 8'd0) begin
      errors++; $display("FAIL serve_clears_rally: rally=%0d, required 0", rally_cnt);
    end
    for (int i = 0; i < 260; i++) begin
      ball_return = 1'b1; tick();
      ball_return = 1'b0; tick();
    end
    checks++;
    if (rally_cnt !== 8'd255 || pos_err !== 1'b0) begin
      errors++; $display("FAIL rally_saturate: rally=%0d pos_err=%b, required 255 0", rally_cnt, pos_err);
    end
  endtask

  initial begin
    test_reset();
    test_serve_rally();
    test_point_hold();
    test_let();
    test_win();
    test_faults();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
